// File: rtl/audio_pkg.sv
// Shared definitions for the audio serial transmitters: mode encodings and
// the elaboration-time legality check for sample/slot/divider parameters.
package audio_pkg;

    typedef enum logic {
        AUD_MODE_I2S = 1'b0,
        AUD_MODE_LJ  = 1'b1
    } aud_mode_e;

    localparam int AUD_SAMPLE_W_MIN = 8;
    localparam int AUD_SAMPLE_W_MAX = 24;

    // A slot needs one spare BCK so the I2S one-bit delay never spills over.
    function automatic bit aud_cfg_ok(input int sample_w, input int slot_w, input int clk_div);
        return (sample_w >= AUD_SAMPLE_W_MIN) && (sample_w <= AUD_SAMPLE_W_MAX) &&
               (slot_w >= sample_w + 1) && (clk_div >= 1);
    endfunction

endpackage

// File: rtl/audio_bck_gen.sv
// Bit-clock generator: a CLK_DIV divider toggles a registered BCK and flags
// the clk cycle whose closing edge takes BCK from 1 to 0.
module audio_bck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic bck,
    output logic fall_stb
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          bck_q;
    logic          bck_d;
    logic          term;

    assign term = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        bck_d = bck_q;
        if (term) begin
            div_d = '0;
            bck_d = ~bck_q;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bck_q <= bck_d;
        end
    end

    assign bck      = bck_q;
    assign fall_stb = term && bck_q;

endmodule

// File: rtl/i2s_tx_multi.sv
// Stereo serial audio transmitter (I2S or left-justified) with a one-entry
// holding register refilled by a valid/ready handshake once per frame.
module i2s_tx_multi
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mode,
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    input  logic                valid,
    output logic                ready,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data,
    output logic                underrun
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] B_SLOT = BW'(SLOT_W);

    if (!aud_cfg_ok(SAMPLE_W, SLOT_W, CLK_DIV)) begin : g_cfg_err
        $error("i2s_tx_multi: illegal SAMPLE_W/SLOT_W/CLK_DIV combination");
    end

    // Serial bit for slot position p of sample s under the given framing.
    function automatic logic data_bit(input logic [SAMPLE_W-1:0] s, input int p,
                                      input aud_mode_e m);
        logic [SAMPLE_W-1:0] sh;
        sh       = '0;
        data_bit = 1'b0;
        if (m == AUD_MODE_LJ) begin
            if (p < SAMPLE_W) begin
                sh       = s >> (SAMPLE_W - 1 - p);
                data_bit = sh[0];
            end
        end else if ((p >= 1) && (p <= SAMPLE_W)) begin
            sh       = s >> (SAMPLE_W - p);
            data_bit = sh[0];
        end
    endfunction

    logic                bck;
    logic                fall_stb;
    logic                frame_start;
    logic                accept;

    logic [BW-1:0]       b_q,        b_d;
    logic                full_q,     full_d;
    logic [SAMPLE_W-1:0] hold_l_q,   hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q,   hold_r_d;
    logic [SAMPLE_W-1:0] left_sr_q,  left_sr_d;
    logic [SAMPLE_W-1:0] right_sr_q, right_sr_d;
    aud_mode_e           mode_q,     mode_d;
    logic                lrck_q,     lrck_d;
    logic                data_q,     data_d;
    logic                underrun_q, underrun_d;
    int                  pos;

    audio_bck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .bck      (bck),
        .fall_stb (fall_stb)
    );

    assign frame_start = fall_stb && (b_q == B_LAST);
    assign accept      = valid && !full_q;

    always_comb begin
        b_d        = b_q;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        mode_d     = mode_q;
        lrck_d     = lrck_q;
        data_d     = data_q;
        underrun_d = 1'b0;
        pos        = 0;

        if (fall_stb) begin
            b_d = frame_start ? '0 : b_q + BW'(1);
        end

        if (frame_start) begin
            mode_d = aud_mode_e'(mode);
            if (full_q) begin
                left_sr_d  = hold_l_q;
                right_sr_d = hold_r_q;
                full_d     = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // An accept can coincide with an empty frame start; it fills for the next frame.
        if (accept) begin
            hold_l_d = left;
            hold_r_d = right;
            full_d   = 1'b1;
        end

        // Outputs are recomputed from the post-edge bit position so they only move as BCK falls.
        if (fall_stb) begin
            lrck_d = (b_d >= B_SLOT);
            pos    = lrck_d ? int'(b_d) - SLOT_W : int'(b_d);
            data_d = data_bit(lrck_d ? right_sr_d : left_sr_d, pos, mode_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q        <= '0;
            full_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            left_sr_q  <= '0;
            right_sr_q <= '0;
            mode_q     <= AUD_MODE_I2S;
            lrck_q     <= 1'b0;
            data_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            b_q        <= b_d;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;
            mode_q     <= mode_d;
            lrck_q     <= lrck_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
        end
    end

    assign ready    = !full_q;
    assign i2s_bck  = bck;
    assign i2s_lrck = lrck_q;
    assign i2s_data = data_q;
    assign underrun = underrun_q;

endmodule
